// File: rtl/core_lsu.sv
// Memory/writeback stage: forwards ALU results to the GPR write port and runs
// loads/stores as a pipelined Wishbone B4 master with one outstanding access.
module core_lsu #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [1:0]  ex_op,
    input  logic [1:0]  ex_size,
    input  logic        ex_signed,
    input  logic [3:0]  ex_wb_addr,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_store_data,
    input  logic        flush,
    output logic        wb_en,
    output logic [3:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        mem_err,
    output logic        dbus_cyc,
    output logic        dbus_stb,
    output logic        dbus_we,
    output logic [31:0] dbus_adr,
    output logic [3:0]  dbus_sel,
    output logic [31:0] dbus_dat_o,
    input  logic [31:0] dbus_dat_i,
    input  logic        dbus_ack,
    input  logic        dbus_err,
    input  logic        dbus_stall
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [31:0] adr_q, adr_d;
    logic [1:0]  size_q, size_d;
    logic        sgn_q, sgn_d;
    logic        we_q, we_d;
    logic [3:0]  waddr_q, waddr_d;
    logic [31:0] sdata_q, sdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        wb_en_q, wb_en_d;
    logic [3:0]  wb_addr_q, wb_addr_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        err_q, err_d;

    logic        accept, misal, fin, to_hit;
    logic [31:0] lane_sh, ld_data;

    assign ex_ready = rst && (state_q == S_IDLE);
    assign accept   = ex_valid && ex_ready && !flush;
    assign misal    = ((ex_size == 2'd1) && ex_result[0]) || (ex_size[1] && (ex_result[1:0] != 2'b00));
    // ack/err while stb is being taken counts as completion in the same cycle
    assign fin      = (state_q == S_WAIT) || ((state_q == S_REQ) && !dbus_stall);
    assign to_hit   = (ACK_TIMEOUT != 0) && (cnt_q == TO_LAST);

    assign lane_sh = dbus_dat_i >> {adr_q[1:0], 3'b000};
    always_comb begin
        case (size_q)
            2'd0:    ld_data = {{24{sgn_q & lane_sh[7]}}, lane_sh[7:0]};
            2'd1:    ld_data = {{16{sgn_q & lane_sh[15]}}, lane_sh[15:0]};
            default: ld_data = dbus_dat_i;
        endcase
    end

    assign dbus_cyc = (state_q != S_IDLE);
    assign dbus_stb = (state_q == S_REQ);
    assign dbus_we  = dbus_cyc && we_q;
    assign dbus_adr = dbus_cyc ? {adr_q[31:2], 2'b00} : 32'd0;

    always_comb begin
        dbus_sel   = 4'b0000;
        dbus_dat_o = 32'd0;
        if (dbus_cyc) begin
            case (size_q)
                2'd0: begin
                    dbus_sel   = 4'b0001 << adr_q[1:0];
                    dbus_dat_o = {4{sdata_q[7:0]}};
                end
                2'd1: begin
                    dbus_sel   = adr_q[1] ? 4'b1100 : 4'b0011;
                    dbus_dat_o = {2{sdata_q[15:0]}};
                end
                default: begin
                    dbus_sel   = 4'b1111;
                    dbus_dat_o = sdata_q;
                end
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        size_d    = size_q;
        sgn_d     = sgn_q;
        we_d      = we_q;
        waddr_d   = waddr_q;
        sdata_d   = sdata_q;
        cnt_d     = cnt_q;
        wb_en_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept && ex_op == 2'd1) begin
                    wb_en_d   = 1'b1;
                    wb_addr_d = ex_wb_addr;
                    wb_data_d = ex_result;
                end else if (accept && ex_op[1]) begin
                    if (misal) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_REQ;
                        adr_d   = ex_result;
                        size_d  = ex_size;
                        sgn_d   = ex_signed;
                        we_d    = ex_op[0];
                        waddr_d = ex_wb_addr;
                        sdata_d = ex_store_data;
                        cnt_d   = 8'd0;
                    end
                end
            end
            S_REQ, S_WAIT: begin
                if (fin && dbus_err) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (fin && dbus_ack) begin
                    state_d = S_IDLE;
                    if (!we_q) begin
                        wb_en_d   = 1'b1;
                        wb_addr_d = waddr_q;
                        wb_data_d = ld_data;
                    end
                end else if (state_q == S_WAIT && to_hit) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (state_q == S_WAIT) begin
                    cnt_d = cnt_q + 8'd1;
                end else if (!dbus_stall) begin
                    state_d = S_WAIT;
                    cnt_d   = 8'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            adr_q     <= 32'd0;
            size_q    <= 2'd0;
            sgn_q     <= 1'b0;
            we_q      <= 1'b0;
            waddr_q   <= 4'd0;
            sdata_q   <= 32'd0;
            cnt_q     <= 8'd0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= 4'd0;
            wb_data_q <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            size_q    <= size_d;
            sgn_q     <= sgn_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            sdata_q   <= sdata_d;
            cnt_q     <= cnt_d;
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            err_q     <= err_d;
        end
    end

    assign wb_en   = wb_en_q;
    assign wb_addr = wb_addr_q;
    assign wb_data = wb_data_q;
    assign mem_err = err_q;
endmodule

// File: tb/tb_core_lsu.sv
// Directed bench for core_lsu: single-cycle ops from a vector table, bus
// transactions as hand-written sequences against hand-computed values.
module tb_core_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_ready, ex_signed, flush;
    logic [1:0]  ex_op, ex_size;
    logic [3:0]  ex_wb_addr, wb_addr, dbus_sel;
    logic [31:0] ex_result, ex_store_data, wb_data, dbus_adr, dbus_dat_o, dbus_dat_i;
    logic        wb_en, mem_err, dbus_cyc, dbus_stb, dbus_we, dbus_ack, dbus_err, dbus_stall;

    int checks = 0;
    int errors = 0;

    core_lsu #(.ACK_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_op(ex_op), .ex_size(ex_size), .ex_signed(ex_signed),
        .ex_wb_addr(ex_wb_addr), .ex_result(ex_result), .ex_store_data(ex_store_data),
        .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .mem_err(mem_err), .dbus_cyc(dbus_cyc), .dbus_stb(dbus_stb), .dbus_we(dbus_we),
        .dbus_adr(dbus_adr), .dbus_sel(dbus_sel), .dbus_dat_o(dbus_dat_o),
        .dbus_dat_i(dbus_dat_i), .dbus_ack(dbus_ack), .dbus_err(dbus_err),
        .dbus_stall(dbus_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        flush;
        logic [1:0]  op;
        logic [1:0]  size;
        logic [3:0]  waddr;
        logic [31:0] result;
        logic        e_wb_en;
        logic [3:0]  e_wb_addr;
        logic [31:0] e_wb_data;
        logic        e_err;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        ex_valid = 0; ex_op = 0; ex_size = 0; ex_signed = 0; ex_wb_addr = 0;
        ex_result = 0; ex_store_data = 0; flush = 0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [1:0] size, input logic sgn,
                         input logic [3:0] wa, input logic [31:0] adr, input logic [31:0] sd);
        ex_valid = 1; ex_op = op; ex_size = size; ex_signed = sgn; ex_wb_addr = wa;
        ex_result = adr; ex_store_data = sd; flush = 0;
        step();
        idle_in();
    endtask

    initial begin
        vecs[0] = '{1, 0, 2'd1, 2'd0, 4'd5,  32'h12345678, 1, 4'd5,  32'h12345678, 0};
        vecs[1] = '{1, 1, 2'd1, 2'd0, 4'd6,  32'h11111111, 0, 4'd5,  32'h12345678, 0};
        vecs[2] = '{1, 0, 2'd0, 2'd0, 4'd7,  32'h22222222, 0, 4'd5,  32'h12345678, 0};
        vecs[3] = '{0, 0, 2'd1, 2'd0, 4'd8,  32'h33333333, 0, 4'd5,  32'h12345678, 0};
        vecs[4] = '{1, 0, 2'd1, 2'd2, 4'd15, 32'hFFFFFFFF, 1, 4'd15, 32'hFFFFFFFF, 0};
        vecs[5] = '{1, 0, 2'd2, 2'd2, 4'd3,  32'h00000101, 0, 4'd15, 32'hFFFFFFFF, 1};
        vecs[6] = '{1, 0, 2'd3, 2'd1, 4'd3,  32'h00000103, 0, 4'd15, 32'hFFFFFFFF, 1};

        rst = 0; idle_in();
        dbus_dat_i = 0; dbus_ack = 0; dbus_err = 0; dbus_stall = 0;
        step(); step();
        chk("rst_wb_en", 32'(wb_en), 0);
        chk("rst_cyc", 32'(dbus_cyc), 0);
        chk("rst_err", 32'(mem_err), 0);
        chk("rst_ready", 32'(ex_ready), 0);
        rst = 1; #1;
        chk("rst_ready_hi", 32'(ex_ready), 1);

        for (int i = 0; i < 7; i++) begin
            ex_valid = vecs[i].valid; flush = vecs[i].flush; ex_op = vecs[i].op;
            ex_size = vecs[i].size; ex_wb_addr = vecs[i].waddr; ex_result = vecs[i].result;
            step();
            chk($sformatf("v%0d_wb_en", i), 32'(wb_en), 32'(vecs[i].e_wb_en));
            chk($sformatf("v%0d_wb_addr", i), 32'(wb_addr), 32'(vecs[i].e_wb_addr));
            chk($sformatf("v%0d_wb_data", i), wb_data, vecs[i].e_wb_data);
            chk($sformatf("v%0d_err", i), 32'(mem_err), 32'(vecs[i].e_err));
            chk($sformatf("v%0d_cyc", i), 32'(dbus_cyc), 0);
        end
        idle_in(); step();
        chk("idle_err_clear", 32'(mem_err), 0);

        // word store, ack on second wait cycle
        issue(2'd3, 2'd2, 0, 4'd1, 32'h100, 32'hDEADBEEF);
        chk("st_stb", 32'(dbus_stb), 1);
        chk("st_we", 32'(dbus_we), 1);
        chk("st_sel", 32'(dbus_sel), 32'hF);
        chk("st_adr", dbus_adr, 32'h100);
        chk("st_dat", dbus_dat_o, 32'hDEADBEEF);
        chk("st_ready", 32'(ex_ready), 0);
        step();
        chk("st_w_stb", 32'(dbus_stb), 0);
        chk("st_w_cyc", 32'(dbus_cyc), 1);
        step();
        chk("st_w2_ready", 32'(ex_ready), 0);
        dbus_ack = 1; step(); dbus_ack = 0;
        chk("st_done_cyc", 32'(dbus_cyc), 0);
        chk("st_done_ready", 32'(ex_ready), 1);
        chk("st_no_wb", 32'(wb_en), 0);
        chk("st_no_err", 32'(mem_err), 0);

        // signed byte load with 3 stalled cycles
        dbus_stall = 1;
        issue(2'd2, 2'd0, 1, 4'd7, 32'h203, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("lb_hold%0d_stb", i), 32'(dbus_stb), 1);
            chk($sformatf("lb_hold%0d_adr", i), dbus_adr, 32'h200);
            chk($sformatf("lb_hold%0d_sel", i), 32'(dbus_sel), 32'h8);
            if (i == 2) dbus_stall = 0;
            step();
        end
        chk("lb_wait_stb", 32'(dbus_stb), 0);
        dbus_dat_i = 32'h80000000; dbus_ack = 1; step(); dbus_ack = 0;
        chk("lb_wb_en", 32'(wb_en), 1);
        chk("lb_wb_addr", 32'(wb_addr), 7);
        chk("lb_wb_data", wb_data, 32'hFFFFFF80);
        step();
        chk("lb_wb_pulse", 32'(wb_en), 0);

        // unsigned byte load, ack while stb is taken
        issue(2'd2, 2'd0, 0, 4'd9, 32'h203, 32'h0);
        dbus_ack = 1; step(); dbus_ack = 0;
        chk("lbu_wb_en", 32'(wb_en), 1);
        chk("lbu_wb_data", wb_data, 32'h00000080);
        chk("lbu_cyc", 32'(dbus_cyc), 0);

        // half load upper lane, unsigned
        issue(2'd2, 2'd1, 0, 4'd2, 32'h102, 32'h0);
        chk("lh_sel", 32'(dbus_sel), 32'hC);
        step();
        dbus_dat_i = 32'hABCD1234; dbus_ack = 1; step(); dbus_ack = 0;
        chk("lh_wb_data", wb_data, 32'h0000ABCD);
        chk("lh_wb_en", 32'(wb_en), 1);

        // byte and half stores: lane select and replication
        issue(2'd3, 2'd0, 0, 4'd0, 32'h101, 32'h000000A5);
        chk("sb_sel", 32'(dbus_sel), 32'h2);
        chk("sb_dat", dbus_dat_o, 32'hA5A5A5A5);
        dbus_ack = 1; step(); dbus_ack = 0;
        issue(2'd3, 2'd1, 0, 4'd0, 32'h102, 32'h00001234);
        chk("sh_sel", 32'(dbus_sel), 32'hC);
        chk("sh_dat", dbus_dat_o, 32'h12341234);
        dbus_ack = 1; step(); dbus_ack = 0;
        chk("sh_done_wb", 32'(wb_en), 0);

        // bus error wins over ack
        issue(2'd2, 2'd2, 0, 4'd4, 32'h300, 32'h0);
        step();
        dbus_err = 1; dbus_ack = 1; step(); dbus_err = 0; dbus_ack = 0;
        chk("be_err", 32'(mem_err), 1);
        chk("be_wb", 32'(wb_en), 0);
        chk("be_cyc", 32'(dbus_cyc), 0);
        step();
        chk("be_err_pulse", 32'(mem_err), 0);

        // timeout after 4 WAIT_ACK cycles
        issue(2'd2, 2'd2, 0, 4'd4, 32'h400, 32'h0);
        step();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to_wait%0d_cyc", i), 32'(dbus_cyc), 1);
            chk($sformatf("to_wait%0d_err", i), 32'(mem_err), 0);
            step();
        end
        chk("to_cyc", 32'(dbus_cyc), 0);
        chk("to_err", 32'(mem_err), 1);

        // reset during WAIT_ACK, late ack ignored
        issue(2'd2, 2'd2, 0, 4'd4, 32'h500, 32'h0);
        step();
        rst = 0; step(); rst = 1;
        chk("rw_cyc", 32'(dbus_cyc), 0);
        dbus_ack = 1; dbus_dat_i = 32'h5A5A5A5A; step(); dbus_ack = 0;
        chk("rw_late_wb", 32'(wb_en), 0);
        chk("rw_late_err", 32'(mem_err), 0);
        chk("rw_ready", 32'(ex_ready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
